pattern_gen: RTL
================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter SHOW_CYCLES, default 100_000_000; number of clock cycles the pattern is displayed (1 s at 100 MHz).
REQ-002 Parameter LFSR_SEED, default 16'hACE1; LFSR reset value, SHALL be nonzero.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  request a new pattern; sampled only in IDLE.
REQ-006 level  input  2  difficulty: 1 = 3x3 grid, 2 = 4x4, 3 = 5x5, 0 = illegal.
REQ-007 busy  output  1  high while a request is being served (GEN, SHOW, DONE).
REQ-008 disp  output  1  high while the pattern is shown to the player (SHOW).
REQ-009 valid  output  1  one-cycle pulse: pattern complete and display finished.
REQ-010 seq1  output  9  3x3 pattern, bit i = cell i, row-major.
REQ-011 seq2  output  16  4x4 pattern, row-major.
REQ-012 seq3  output  25  5x5 pattern, row-major.

Function
REQ-013 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL advance every cycle in every state, including IDLE.
REQ-014 Grid size N and target count K per level: level 1 -> N=9, K=3; level 2 -> N=16, K=5; level 3 -> N=25, K=7.
REQ-015 FSM states: IDLE, GEN, SHOW, DONE; all outputs registered.
REQ-016 IDLE: on req=1 with level != 0, latch level, clear seq1/seq2/seq3 and the hit counter, go to GEN; busy=1 from the next cycle.
REQ-017 IDLE: req=1 with level=0 SHALL be ignored; state, outputs and held patterns are unchanged.
REQ-018 GEN, per cycle: idx = lfsr[4:0]; accept if idx < N and bit idx of the active seq is 0; on accept, set that bit and increment the counter.
REQ-019 GEN: only the seq for the latched level is written; the other two SHALL stay 0.
REQ-020 GEN: on the edge where an accept brings the count to K, go to SHOW.
REQ-021 SHOW: disp=1 for exactly SHOW_CYCLES cycles, counted by a cycle counter cleared on entry; then go to DONE.
REQ-022 DONE: valid=1 for exactly one cycle, disp=0; then go to IDLE.
REQ-023 Patterns SHALL hold their value from the end of GEN until the next accepted req or reset.
REQ-024 req is ignored in GEN, SHOW and DONE; level changes after latching have no effect.
REQ-025 Popcount of the active seq SHALL equal K at valid; no bit at or above index N is ever set.
REQ-026 disp and valid are never high in the same cycle.

Reset
REQ-027 When reset=1 at a rising edge, the next state is IDLE in any state, including mid-GEN or mid-SHOW.
REQ-028 Reset values: busy=0, disp=0, valid=0, seq1=0, seq2=0, seq3=0, hit counter=0, display counter=0, latched level=0, lfsr=LFSR_SEED.
REQ-029 reset has priority over req in the same cycle.

Verification (SHOW_CYCLES=4)
REQ-030 Reset held 2 cycles -> all outputs 0; on release, lfsr=16'hACE1.
REQ-031 req=1, level=1 for 1 cycle -> busy=1 next cycle; in GEN, seq1 popcount reaches 3; disp=1 for exactly 4 cycles; valid=1 for 1 cycle; seq2=seq3=0; then busy=0 and seq1 held.
REQ-032 req=1 with level=3 -> seq3 popcount 7 at valid; seq1=seq2=0; repeat with level=2 -> seq2 popcount 5, seq3 cleared.
REQ-033 req=1 with level=0 in IDLE -> busy stays 0 and the previous pattern is unchanged for 10 cycles.
REQ-034 req pulsed during SHOW -> ignored; exactly one valid pulse; disp width still 4 cycles.
REQ-035 reset asserted mid-GEN and mid-SHOW -> next cycle busy=0, disp=0, valid=0, all seq=0; a new req then completes normally.

Source files
------------

// File: rtl/pattern_gen.sv
// Random memory-grid pattern generator: picks K distinct cells of an NxN grid from a
// free-running LFSR, then shows the pattern for SHOW_CYCLES cycles and pulses valid.
module pattern_gen #(
    parameter int          SHOW_CYCLES = 100_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  level,
    output logic        busy,
    output logic        disp,
    output logic        valid,
    output logic [8:0]  seq1,
    output logic [15:0] seq2,
    output logic [24:0] seq3
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GEN  = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              CNT_W    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [1:0]       level_q, level_d;
    logic [2:0]       hits_q, hits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       seq1_q, seq1_d;
    logic [15:0]      seq2_q, seq2_d;
    logic [24:0]      seq3_q, seq3_d;
    logic             busy_q, busy_d;
    logic             disp_q, disp_d;
    logic             valid_q, valid_d;

    logic [4:0]  idx;
    logic [24:0] hot;
    logic [4:0]  grid_n;
    logic [2:0]  target_k;
    logic        cell_free;
    logic        accept;
    logic [2:0]  hits_inc;

    always_comb begin
        idx      = lfsr_q[4:0];
        hot      = 25'd1 << idx;
        hits_inc = hits_q + 3'd1;

        grid_n    = 5'd0;
        target_k  = 3'd0;
        cell_free = 1'b0;
        case (level_q)
            2'd1: begin grid_n = 5'd9;  target_k = 3'd3; cell_free = ((seq1_q & hot[8:0])  == '0); end
            2'd2: begin grid_n = 5'd16; target_k = 3'd5; cell_free = ((seq2_q & hot[15:0]) == '0); end
            2'd3: begin grid_n = 5'd25; target_k = 3'd7; cell_free = ((seq3_q & hot)       == '0); end
            default: ;
        endcase
        accept = (idx < grid_n) && cell_free;

        // LFSR runs in every state so the seed a request sees depends on when it arrives
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d = state_q;
        level_d = level_q;
        hits_d  = hits_q;
        cnt_d   = cnt_q;
        seq1_d  = seq1_q;
        seq2_d  = seq2_q;
        seq3_d  = seq3_q;

        case (state_q)
            S_IDLE: begin
                if (req && (level != 2'd0)) begin
                    level_d = level;
                    hits_d  = 3'd0;
                    seq1_d  = '0;
                    seq2_d  = '0;
                    seq3_d  = '0;
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                if (accept) begin
                    hits_d = hits_inc;
                    case (level_q)
                        2'd1:    seq1_d = seq1_q | hot[8:0];
                        2'd2:    seq2_d = seq2_q | hot[15:0];
                        default: seq3_d = seq3_q | hot;
                    endcase
                    if (hits_inc == target_k) begin
                        cnt_d   = '0;
                        state_d = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        disp_d  = (state_d == S_SHOW);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            level_q <= 2'd0;
            hits_q  <= 3'd0;
            cnt_q   <= '0;
            seq1_q  <= '0;
            seq2_q  <= '0;
            seq3_q  <= '0;
            busy_q  <= 1'b0;
            disp_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            level_q <= level_d;
            hits_q  <= hits_d;
            cnt_q   <= cnt_d;
            seq1_q  <= seq1_d;
            seq2_q  <= seq2_d;
            seq3_q  <= seq3_d;
            busy_q  <= busy_d;
            disp_q  <= disp_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = busy_q;
    assign disp  = disp_q;
    assign valid = valid_q;
    assign seq1  = seq1_q;
    assign seq2  = seq2_q;
    assign seq3  = seq3_q;

endmodule
